// File: rtl/wb_grf_pkg.sv
// Shared CPU encodings for the write-back source select and load type.
// Used by the decoder, the M/W pipeline register and the write-back/register-file stage.
package wb_grf_pkg;

    localparam int XLEN    = 32;
    localparam int NREGS   = 32;
    localparam int REG_AW  = 5;

    typedef enum logic [1:0] {
        MEMTOREG_ALU  = 2'b00,
        MEMTOREG_LOAD = 2'b01,
        MEMTOREG_LINK = 2'b10,
        MEMTOREG_RSVD = 2'b11
    } memtoreg_e;

    // Codes 101-111 are reserved and behave like lw.
    typedef enum logic [2:0] {
        LOAD_LW  = 3'b000,
        LOAD_LBU = 3'b001,
        LOAD_LB  = 3'b010,
        LOAD_LHU = 3'b011,
        LOAD_LH  = 3'b100
    } loadop_e;

endpackage

// File: rtl/wb_grf_load_ext.sv
// Load extender: picks the addressed byte/halfword out of the raw memory word
// and sign- or zero-extends it; a misaligned halfword offset bit is ignored.
module load_ext
    import wb_grf_pkg::*;
(
    input  logic [XLEN-1:0] rdw_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      loadop_i,
    output logic [XLEN-1:0] ext_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = 8'(rdw_i >> {offset_i, 3'b000});
    assign half_v = 16'(rdw_i >> {offset_i[1], 4'b0000});

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        ext_o = rdw_i;
        case (loadop_i)
            LOAD_LB:  ext_o = {{24{byte_v[7]}}, byte_v};
            LOAD_LBU: ext_o = {24'd0, byte_v};
            LOAD_LH:  ext_o = {{16{half_v[15]}}, half_v};
            LOAD_LHU: ext_o = {16'd0, half_v};
            default:  ext_o = rdw_i;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// Write-back stage and general register file: selects the write-back data,
// writes it into a 32x32 flop array and serves two bypassed read ports.
module wb_grf
    import wb_grf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic [1:0]        MemtoRegW,
    input  logic [2:0]        LoadopW,
    input  logic [XLEN-1:0]   RDW,
    input  logic [XLEN-1:0]   ALUoutW,
    input  logic [XLEN-1:0]   PC_4W,
    input  logic [REG_AW-1:0] AwriteW,
    input  logic [REG_AW-1:0] A1,
    input  logic [REG_AW-1:0] A2,
    output logic [XLEN-1:0]   RD1,
    output logic [XLEN-1:0]   RD2,
    output logic [XLEN-1:0]   WDW
);

    logic [XLEN-1:0] ext_data;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_en;

    load_ext u_load_ext (
        .rdw_i    (RDW),
        .offset_i (ALUoutW[1:0]),
        .loadop_i (LoadopW),
        .ext_o    (ext_data)
    );

    always_comb begin
        WDW = '0;
        case (MemtoRegW)
            MEMTOREG_ALU:  WDW = ALUoutW;
            MEMTOREG_LOAD: WDW = ext_data;
            MEMTOREG_LINK: WDW = PC_4W + 32'd4;
            default:       WDW = '0;
        endcase
    end

    assign wr_en = RegWriteW && (AwriteW != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[AwriteW] = WDW;
        end
    end

    // NOTE: the array is cleared by reset on purpose; it is built from flops so the
    // synchronous clear and same-cycle bypass are possible, unlike a RAM macro.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Write-through: a write to the addressed register is visible in the same cycle.
    always_comb begin
        RD1 = regs_q[A1];
        RD2 = regs_q[A2];
        if (A1 == '0) begin
            RD1 = '0;
        end else if (wr_en && (AwriteW == A1)) begin
            RD1 = WDW;
        end
        if (A2 == '0) begin
            RD2 = '0;
        end else if (wr_en && (AwriteW == A2)) begin
            RD2 = WDW;
        end
    end

endmodule

// File: tb/tb_wb_grf.sv
// Scoreboarded bench for wb_grf: stimulus queues expected outputs per cycle,
// a monitor compares them mid-cycle; random traffic runs against a reference model.
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteW;
    logic [1:0]  MemtoRegW;
    logic [2:0]  LoadopW;
    logic [31:0] RDW, ALUoutW, PC_4W;
    logic [4:0]  AwriteW, A1, A2;
    logic [31:0] RD1, RD2, WDW;

    always #5 clk = ~clk;

    wb_grf dut (
        .clk       (clk),
        .reset     (reset),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .LoadopW   (LoadopW),
        .RDW       (RDW),
        .ALUoutW   (ALUoutW),
        .PC_4W     (PC_4W),
        .AwriteW   (AwriteW),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .WDW       (WDW)
    );

    typedef enum int {SEL_RD1, SEL_RD2, SEL_WDW} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } item_t;

    item_t       sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_regs [32];

    // Reference model of the write-back value, from the load/extension rules.
    function automatic logic [31:0] model_wdw();
        logic [31:0] b, h, ext;
        b = (RDW >> (8 * ALUoutW[1:0])) & 32'hFF;
        h = (RDW >> (16 * ALUoutW[1])) & 32'hFFFF;
        case (LoadopW)
            3'd0:    ext = RDW;
            3'd1:    ext = b;
            3'd2:    ext = (b ^ 32'h80) - 32'h80;
            3'd3:    ext = h;
            3'd4:    ext = (h ^ 32'h8000) - 32'h8000;
            default: ext = RDW;
        endcase
        case (MemtoRegW)
            2'd0:    return ALUoutW;
            2'd1:    return ext;
            2'd2:    return PC_4W + 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWriteW && AwriteW == a) return model_wdw();
        return model_regs[a];
    endfunction

    task automatic expect_val(input string name, input sel_e sel, input logic [31:0] exp);
        item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    // Advance one clock: the monitor checks queued items at the falling edge,
    // then the model commits the same write the DUT should perform.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        end else if (RegWriteW && AwriteW != 5'd0) begin
            model_regs[AwriteW] = model_wdw();
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; RegWriteW = 1'b0; MemtoRegW = 2'd0; LoadopW = 3'd0;
        RDW = '0; ALUoutW = '0; PC_4W = '0; AwriteW = '0; A1 = '0; A2 = '0;
    endtask

    initial begin : monitor
        item_t       it;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                case (it.sel)
                    SEL_RD1: act = RD1;
                    SEL_RD2: act = RD2;
                    default: act = WDW;
                endcase
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s: got %08h want %08h", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin : stim
        int wait_cycles;
        idle_inputs();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        reset = 1'b1;
        #1;
        step();

        reset = 1'b0; A1 = 5'd5; A2 = 5'd31;
        expect_val("reset_rd1", SEL_RD1, 32'h0);
        expect_val("reset_rd2", SEL_RD2, 32'h0);
        step();

        RegWriteW = 1'b1; MemtoRegW = 2'b00; ALUoutW = 32'h1234_5678; AwriteW = 5'd8; A1 = 5'd8;
        expect_val("bypass_rd1", SEL_RD1, 32'h1234_5678);
        step();
        RegWriteW = 1'b0; ALUoutW = 32'h0;
        expect_val("array_rd1", SEL_RD1, 32'h1234_5678);
        step();

        MemtoRegW = 2'b01; RDW = 32'h80FF_7F01;
        LoadopW = 3'b010; ALUoutW = 32'h3;
        expect_val("lb_off3", SEL_WDW, 32'hFFFF_FF80);
        step();
        LoadopW = 3'b001; ALUoutW = 32'h3;
        expect_val("lbu_off3", SEL_WDW, 32'h0000_0080);
        step();
        LoadopW = 3'b100; ALUoutW = 32'h2;
        expect_val("lh_off2", SEL_WDW, 32'hFFFF_80FF);
        step();
        LoadopW = 3'b011; ALUoutW = 32'h0;
        expect_val("lhu_off0", SEL_WDW, 32'h0000_7F01);
        step();
        LoadopW = 3'b000; ALUoutW = 32'h2;
        expect_val("lw", SEL_WDW, 32'h80FF_7F01);
        step();
        LoadopW = 3'b011; ALUoutW = 32'h3;
        expect_val("lhu_misaligned", SEL_WDW, 32'h0000_80FF);
        step();
        LoadopW = 3'b110; ALUoutW = 32'h1;
        expect_val("reserved_loadop", SEL_WDW, 32'h80FF_7F01);
        step();

        RegWriteW = 1'b1; MemtoRegW = 2'b10; PC_4W = 32'h0000_3004; AwriteW = 5'd31;
        step();
        RegWriteW = 1'b0; A2 = 5'd31;
        expect_val("link_r31", SEL_RD2, 32'h0000_3008);
        step();
        PC_4W = 32'hFFFF_FFFC;
        expect_val("link_wrap", SEL_WDW, 32'h0000_0000);
        MemtoRegW = 2'b10;
        step();
        MemtoRegW = 2'b11;
        expect_val("memtoreg_rsvd", SEL_WDW, 32'h0);
        step();

        RegWriteW = 1'b1; MemtoRegW = 2'b00; AwriteW = 5'd0; ALUoutW = 32'hDEAD_BEEF; A1 = 5'd0;
        expect_val("r0_before", SEL_RD1, 32'h0);
        step();
        RegWriteW = 1'b0;
        expect_val("r0_after", SEL_RD1, 32'h0);
        step();

        RegWriteW = 1'b1; AwriteW = 5'd7; ALUoutW = 32'h0BAD_F00D; A1 = 5'd7; A2 = 5'd7;
        expect_val("same_addr_rd1", SEL_RD1, 32'h0BAD_F00D);
        expect_val("same_addr_rd2", SEL_RD2, 32'h0BAD_F00D);
        step();

        AwriteW = 5'd4; ALUoutW = 32'hA5A5_A5A5;
        step();
        RegWriteW = 1'b0; A1 = 5'd4;
        expect_val("r4_written", SEL_RD1, 32'hA5A5_A5A5);
        step();
        reset = 1'b1; RegWriteW = 1'b1; AwriteW = 5'd4; ALUoutW = 32'h1;
        step();
        reset = 1'b0; RegWriteW = 1'b0;
        expect_val("r4_after_reset", SEL_RD1, 32'h0);
        expect_val("r8_after_reset", SEL_RD2, 32'h0);
        A2 = 5'd8;
        step();

        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 39) == 0);
            RegWriteW = $urandom_range(0, 1) == 1;
            MemtoRegW = 2'($urandom_range(0, 3));
            LoadopW   = 3'($urandom_range(0, 7));
            RDW       = $urandom;
            ALUoutW   = $urandom;
            PC_4W     = $urandom;
            AwriteW   = 5'($urandom_range(0, 31));
            A1        = ($urandom_range(0, 3) == 0) ? AwriteW : 5'($urandom_range(0, 31));
            A2        = ($urandom_range(0, 3) == 0) ? A1 : 5'($urandom_range(0, 31));
            expect_val("rand_wdw", SEL_WDW, model_wdw());
            expect_val("rand_rd1", SEL_RD1, model_read(A1));
            expect_val("rand_rd2", SEL_RD2, model_read(A2));
            step();
        end

        idle_inputs();
        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
